data_bus_responder: RTL

- Target side of the single-cycle core's data-memory bus (write_enable/adr/din/dout).
- Serves a word RAM plus three memory-mapped registers: console TX FIFO, status, free-running cycle counter.
- The TX FIFO drains to an external byte sink over valid/ready.
- Reads are combinational, so the core completes loads in one cycle; writes commit on the rising clk edge.

---
 rtl/data_bus_responder.sv | 111 +++++++++++
 1 files changed

// File: rtl/data_bus_responder.sv
// Data-memory bus target for the single-cycle core: word RAM plus console TX FIFO,
// status and free-running cycle-counter registers. Reads are combinational, writes commit on clk.
module data_bus_responder #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        write_enable,
  input  logic [31:0] adr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bad_addr
);
  localparam int          RA        = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [29:0] MMIO_WORD = MMIO_BASE[31:2];

  logic [31:0]   ram_q [RAM_WORDS];
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          bad_addr_q, bad_addr_d;

  logic [29:0]   word_idx;
  logic [RA-1:0] ram_idx;
  logic          hit_ram, hit_tx, hit_st, hit_cy;
  logic          full, empty, pop, push_req, push;
  logic [31:0]   status_word;
  logic          unused_adr_bits;

  assign word_idx        = adr[31:2];
  assign ram_idx         = adr[RA+1:2];
  assign unused_adr_bits = ^adr[1:0];

  assign hit_ram = (adr[31:RA+2] == '0);
  assign hit_tx  = (word_idx == MMIO_WORD);
  assign hit_st  = (word_idx == MMIO_WORD + 30'd1);
  assign hit_cy  = (word_idx == MMIO_WORD + 30'd2);

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign tx_valid = !empty;
  assign tx_data  = fifo_mem_q[rd_ptr_q];
  assign bad_addr = bad_addr_q;

  // count is reported in a 4-bit field; a 16-deep full FIFO reads back as 0 there.
  assign status_word = ((32'(count_q) << 4) & 32'h0000_00F0)
                     | {29'b0, overflow_q, full, empty};

  always_comb begin
    dout = '0;
    if (hit_ram)     dout = ram_q[ram_idx];
    else if (hit_st) dout = status_word;
    else if (hit_cy) dout = cycle_q;
  end

  always_comb begin
    pop      = tx_valid && tx_ready;
    push_req = write_enable && hit_tx;
    push     = push_req && (!full || pop);

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // Clear first so a same-cycle overflow event wins.
    overflow_d = overflow_q;
    if (write_enable && hit_st && din[2]) overflow_d = 1'b0;
    if (push_req && full && !pop)         overflow_d = 1'b1;

    cycle_d    = (write_enable && hit_cy) ? din : cycle_q + 32'd1;
    bad_addr_d = write_enable && !(hit_ram || hit_tx || hit_st || hit_cy);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cycle_q    <= '0;
      bad_addr_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cycle_q    <= cycle_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  // Storage arrays are not reset; only the pointers and count define FIFO contents.
  always_ff @(posedge clk) begin
    if (write_enable && hit_ram) ram_q[ram_idx] <= din;
    if (push)                    fifo_mem_q[wr_ptr_q] <= din[7:0];
  end
endmodule
